// File: rtl/rns_mul_sequencer.sv
// Sequential RNS modular multiplier: one shift-add modular multiply datapath
// time-shared across all residue domains, one multiplier bit per cycle.
module rns_mul_sequencer #(
    parameter int                       NUM_DOMAINS = 2,
    parameter logic [NUM_DOMAINS*9-1:0] MODULI      = {9'd129, 9'd256}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       flush,
    input  logic [NUM_DOMAINS*8-1:0]   op1,
    input  logic [NUM_DOMAINS*8-1:0]   op2,
    output logic                       busy,
    output logic                       stall_req,
    output logic                       done,
    output logic [NUM_DOMAINS*8-1:0]   result
);

    localparam int            DW       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [DW-1:0] LAST_DOM = DW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [DW-1:0]               dom_q, dom_d;
    logic [2:0]                  bit_q, bit_d;
    logic [7:0]                  acc_q, acc_d;
    logic [NUM_DOMAINS*8-1:0]    result_q, result_d;
    logic [NUM_DOMAINS*8-1:0]    a_q, b_q;
    logic [NUM_DOMAINS*8-1:0]    a_red, b_red;
    logic                        load;
    logic [9:0]                  m_cur;
    logic [7:0]                  a_cur, b_cur;
    logic [9:0]                  t_dbl, t_add;

    // Moduli are >= 128, so one conditional subtract fully reduces an 8-bit slice.
    function automatic logic [7:0] reduce(input logic [7:0] x, input logic [8:0] m);
        return ({1'b0, x} >= m) ? 8'({1'b0, x} - m) : x;
    endfunction

    always_comb begin
        a_red = '0;
        b_red = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            a_red[i*8 +: 8] = reduce(op1[i*8 +: 8], MODULI[i*9 +: 9]);
            b_red[i*8 +: 8] = reduce(op2[i*8 +: 8], MODULI[i*9 +: 9]);
        end
    end

    always_comb begin
        m_cur = '0;
        a_cur = '0;
        b_cur = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (dom_q == DW'(i)) begin
                m_cur = {1'b0, MODULI[i*9 +: 9]};
                a_cur = a_q[i*8 +: 8];
                b_cur = b_q[i*8 +: 8];
            end
        end
    end

    // One MSB-first step: acc = (2*acc + b[bit]*a) mod m, kept in 10 bits.
    // NOTE: blocking assignments here build a chain of combinational stages;
    // each line reads the value produced by the line above it.
    always_comb begin
        t_dbl = {1'b0, acc_q, 1'b0};
        if (t_dbl >= m_cur) t_dbl = t_dbl - m_cur;
        t_add = t_dbl;
        if (b_cur[bit_q]) begin
            t_add = t_dbl + {2'b00, a_cur};
            if (t_add >= m_cur) t_add = t_add - m_cur;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        dom_d    = dom_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        result_d = result_q;
        load     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                    dom_d   = '0;
                    bit_d   = 3'd7;
                    acc_d   = '0;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    dom_d   = '0;
                    bit_d   = '0;
                    acc_d   = '0;
                end else if (bit_q == 3'd0) begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (dom_q == DW'(i)) result_d[i*8 +: 8] = t_add[7:0];
                    end
                    acc_d = '0;
                    bit_d = 3'd7;
                    if (dom_q == LAST_DOM) state_d = S_DONE;
                    else                   dom_d   = dom_q + DW'(1);
                end else begin
                    acc_d = t_add[7:0];
                    bit_d = bit_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                dom_d   = '0;
                bit_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dom_q    <= '0;
            bit_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dom_q    <= dom_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on
    // acceptance before the datapath reads them.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a_red;
            b_q <= b_red;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign stall_req = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);
    assign result    = result_q;

endmodule

// File: tb/tb_rns_mul_sequencer.sv
// Scoreboard bench for rns_mul_sequencer: stimulus pushes expected products,
// an independent monitor pops and compares on every done pulse.
module tb_rns_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [15:0] result;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] exp_q[$];
    int          due_q[$];
    logic [15:0] last_res;

    rns_mul_sequencer #(
        .NUM_DOMAINS(2),
        .MODULI     ({9'd129, 9'd256})
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .op1      (op1),
        .op2      (op2),
        .busy     (busy),
        .stall_req(stall_req),
        .done     (done),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Domain 0 uses modulus 256, domain 1 uses 129.
    function automatic int mod_of(input int d);
        return (d == 0) ? 256 : 129;
    endfunction

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int x, y;
        r = '0;
        for (int d = 0; d < 2; d++) begin
            x = int'(a[d*8 +: 8]);
            y = int'(b[d*8 +: 8]);
            r[d*8 +: 8] = 8'((x * y) % mod_of(d));
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [15:0] e;
        int          due;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e   = exp_q.pop_front();
                due = due_q.pop_front();
                check("result", {16'd0, result}, {16'd0, e});
                check("latency", cyc, due);
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after acceptance.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
        start = 1'b1;
        op1   = a;
        op2   = b;
        @(negedge clk);
        check("stall_on_start", {31'd0, stall_req}, 32'd1);
        @(posedge clk);
        #1;
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done();
        bit seen;
        int stalls;
        seen   = 1'b0;
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall_req) stalls++;
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
        check("stall_cycles", stalls, 16);
        check("stall_in_done", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        int e;
        issue(a, b, e);
        exp_q.push_back(exp);
        due_q.push_back(e + 16);
        last_res = exp;
        wait_done();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          e;
        logic [15:0] a, b, c_exp, b_exp;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op1   = '0;
        op2   = '0;
        last_res = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        @(posedge clk);
        #1;

        // Directed values with hand-derived products.
        do_op({8'd100, 8'd200}, {8'd50, 8'd3},   {8'd98, 8'd88});
        do_op({8'd128, 8'd255}, {8'd128, 8'd255}, {8'd1, 8'd1});
        do_op({8'd0, 8'd16},    {8'd77, 8'd16},   {8'd0, 8'd0});
        do_op({8'd130, 8'd7},   {8'd2, 8'd9},     {8'd2, 8'd63});

        // start held high across the whole op with new operands presented.
        a     = 16'($urandom);
        b     = 16'($urandom);
        b_exp = model(16'($urandom_range(0, 65535)), 16'd0);
        start = 1'b1;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        e   = cyc;
        op1 = {8'd201, 8'd17};
        op2 = {8'd99, 8'd250};
        b_exp = model(op1, op2);
        exp_q.push_back(model(a, b));
        due_q.push_back(e + 16);
        exp_q.push_back(b_exp);
        due_q.push_back(e + 34);
        repeat (18) @(posedge clk);
        #1;
        start = 1'b0;
        drain("held_start_drain");
        last_res = b_exp;

        // Randomised operands across the full 8-bit range.
        for (int n = 0; n < 20; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            do_op(a, b, model(a, b));
        end

        // Flush in RUN cycle 10 (domain 1): domain 0 updated, domain 1 kept.
        a     = {8'd33, 8'd91};
        b     = {8'd64, 8'd205};
        c_exp = model(a, b);
        issue(a, b, e);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, busy}, 32'd0);
        check("flush_result", {16'd0, result}, {16'd0, last_res[15:8], c_exp[7:0]});
        last_res = {last_res[15:8], c_exp[7:0]};
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        // Flush together with start in IDLE blocks acceptance.
        start = 1'b1;
        flush = 1'b1;
        op1   = 16'($urandom);
        op2   = 16'($urandom);
        @(negedge clk);
        check("flush_start_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        check("flush_start_result", {16'd0, result}, {16'd0, last_res});

        // Flush in DONE does not suppress the done pulse.
        a = 16'($urandom);
        b = 16'($urandom);
        issue(a, b, e);
        exp_q.push_back(model(a, b));
        due_q.push_back(e + 16);
        last_res = model(a, b);
        repeat (16) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("done_despite_flush", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("idle_after_flush_done", {31'd0, busy}, 32'd0);
        drain("flush_done_drain");

        // Reset at RUN cycle 5 clears everything.
        issue(16'($urandom), 16'($urandom), e);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun_reset_busy", {31'd0, busy}, 32'd0);
        check("midrun_reset_result", {16'd0, result}, 32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        a = 16'($urandom);
        b = 16'($urandom);
        do_op(a, b, model(a, b));

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
